// File: rtl/sha1_wb_master.sv
// Wishbone bus master that pushes one 512-bit block through a memory-mapped
// SHA1 peripheral: ID check, engine reset, message load, DONE poll, digest read.
//
// state   | meaning
// IDLE    | waiting for start_i
// CHK_ID  | read ID register and compare against the SHA1 signature
// ENG_RST | write control register with reset=1, on=0
// MSG_WR  | write message words 0..15 into MSG_IN
// POLL    | read control register until DONE (or PANIC)
// DIG_RD  | read five digest words into digest_o
// FIN     | one-cycle done_o pulse
// ERR     | one-cycle err_o pulse, err_code_o holds the cause
module sha1_wb_master #(
    parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
    parameter int          TIMEOUT      = 1024
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_n_i,
    input  logic         start_i,
    input  logic [511:0] msg_i,
    output logic [159:0] digest_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [1:0]   err_code_o,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic         wbm_we_o,
    output logic [3:0]   wbm_sel_o,
    output logic [31:0]  wbm_adr_o,
    output logic [31:0]  wbm_dat_o,
    input  logic [31:0]  wbm_dat_i,
    input  logic         wbm_ack_i
);
    localparam logic [31:0] ADR_ID   = BASE_ADDRESS + 32'd4;
    localparam logic [31:0] ADR_CTRL = BASE_ADDRESS + 32'd8;
    localparam logic [31:0] ADR_MSG  = BASE_ADDRESS + 32'd12;
    localparam logic [31:0] ADR_DIG  = BASE_ADDRESS + 32'd16;
    localparam logic [31:0] SHA1_ID  = 32'h53484131;
    localparam logic [31:0] EBUSY    = 32'hfffffff0;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, CHK_ID, ENG_RST, MSG_WR, POLL, DIG_RD, FIN, ERR
    } state_t;

    state_t         state, state_n;
    logic           stb_q;
    logic [511:0]   msg_q;
    logic [15:0]    tmo_cnt;
    logic [3:0]     idx;
    logic           need_acc;
    logic           acc_we;
    logic [31:0]    acc_adr;
    logic [31:0]    acc_dat;
    logic [1:0]     code_n;
    logic           acked;
    logic           waiting;
    logic           tmo_hit;
    logic           launch;

    // cyc and stb always move together; sel is all-ones whenever a cycle is open
    assign wbm_cyc_o = stb_q;
    assign wbm_stb_o = stb_q;
    assign wbm_sel_o = {4{stb_q}};

    assign acked   = stb_q & wbm_ack_i;
    assign waiting = stb_q & ~wbm_ack_i;
    // POLL counts its whole stay, other states only count ack wait cycles
    assign tmo_hit = ~acked & (waiting | (state == POLL)) & (tmo_cnt == TMO_LAST);
    // a new access needs one cycle seen with stb=0 and ack=0, so a trailing ack is never reused
    assign launch  = need_acc & ~stb_q & ~wbm_ack_i & ~tmo_hit;

    // state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state <= IDLE;
        else             state <= state_n;
    end

    // next state, error code and the access each state wants to issue
    always_comb begin
        state_n  = state;
        code_n   = err_code_o;
        need_acc = 1'b0;
        acc_we   = 1'b0;
        acc_adr  = '0;
        acc_dat  = '0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = CHK_ID;
                    code_n  = 2'd0;
                end
            end
            CHK_ID: begin
                need_acc = 1'b1;
                acc_adr  = ADR_ID;
                if (acked) begin
                    if (wbm_dat_i == SHA1_ID) begin
                        state_n = ENG_RST;
                    end else begin
                        state_n = ERR;
                        code_n  = 2'd1;
                    end
                end
            end
            ENG_RST: begin
                need_acc = 1'b1;
                acc_we   = 1'b1;
                acc_adr  = ADR_CTRL;
                acc_dat  = 32'h2;
                if (acked) state_n = MSG_WR;
            end
            MSG_WR: begin
                need_acc = 1'b1;
                acc_we   = 1'b1;
                acc_adr  = ADR_MSG;
                acc_dat  = msg_q[{idx, 5'd0} +: 32];
                if (acked && idx == 4'd15) state_n = POLL;
            end
            POLL: begin
                need_acc = 1'b1;
                acc_adr  = ADR_CTRL;
                // PANIC wins over DONE: a panicked engine's digest is not trusted
                if (acked) begin
                    if (wbm_dat_i[2]) begin
                        state_n = ERR;
                        code_n  = 2'd2;
                    end else if (wbm_dat_i[3]) begin
                        state_n = DIG_RD;
                    end
                end
            end
            DIG_RD: begin
                need_acc = 1'b1;
                acc_adr  = ADR_DIG;
                if (acked) begin
                    if (wbm_dat_i == EBUSY) begin
                        state_n = ERR;
                        code_n  = 2'd3;
                    end else if (idx == 4'd4) begin
                        state_n = FIN;
                    end
                end
            end
            FIN:     state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (tmo_hit) begin
            state_n = ERR;
            code_n  = 2'd2;
        end
    end

    // bus signals, counters, latched message, digest and status outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            stb_q      <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            msg_q      <= '0;
            tmo_cnt    <= '0;
            idx        <= '0;
            digest_o   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= '0;
        end else begin
            busy_o     <= (state_n != IDLE);
            done_o     <= (state_n == FIN);
            err_o      <= (state_n == ERR);
            err_code_o <= code_n;

            if (state == IDLE && start_i) msg_q <= msg_i;

            if (acked || tmo_hit) begin
                stb_q     <= 1'b0;
                wbm_we_o  <= 1'b0;
                wbm_adr_o <= '0;
                wbm_dat_o <= '0;
            end else if (launch) begin
                stb_q     <= 1'b1;
                wbm_we_o  <= acc_we;
                wbm_adr_o <= acc_adr;
                wbm_dat_o <= acc_dat;
            end

            if (state_n == POLL && state != POLL)     tmo_cnt <= '0;
            else if (launch && state != POLL)         tmo_cnt <= '0;
            else if (waiting || state == POLL)        tmo_cnt <= tmo_cnt + 16'd1;

            if (state_n != state)                                   idx <= '0;
            else if (acked && (state == MSG_WR || state == DIG_RD)) idx <= idx + 4'd1;

            if (state == DIG_RD && acked && wbm_dat_i != EBUSY) begin
                for (int k = 0; k < 5; k++) begin
                    if (idx == 4'(k)) digest_o[32*k +: 32] <= wbm_dat_i;
                end
            end
        end
    end
endmodule
